// File: rtl/whackamole_pkg.sv
// Shared definitions for the whack-a-mole game controller slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package whackamole_pkg;

  // Number of moles on the board; sets the button and position widths.
  localparam int NUM_MOLES            = 5;
  localparam int DEFAULT_GAME_SECONDS = 30;
  // Width of a per-cycle hit count (0..NUM_MOLES).
  localparam int HIT_CNT_W            = $clog2(NUM_MOLES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } game_state_e;

endpackage

// File: rtl/whackamole_game_ctrl_if.sv
// Game-controller signal bundle: button/tick/mole inputs and the game outputs.
// Latency: n/a (wiring only).
// Backpressure: none; every input is a one-cycle pulse or a level.
// master: drives the inputs (board side); slave: the controller.
interface whackamole_game_ctrl_if
  import whackamole_pkg::*;
#(
  parameter int SCORE_W = 8,
  parameter int TIME_W  = 6
);
  logic                 startPulse;
  logic                 tick;
  logic [NUM_MOLES-1:0] moleButtonPulses;
  logic [NUM_MOLES-1:0] molePositions;
  logic                 gameEnable;
  logic [SCORE_W-1:0]   score;
  logic [SCORE_W-1:0]   bestScore;
  logic [TIME_W-1:0]    timeLeft;
  logic                 hitPulse;
  logic                 missPulse;
  logic                 gameOver;

  modport master (
    output startPulse, tick, moleButtonPulses, molePositions,
    input  gameEnable, score, bestScore, timeLeft, hitPulse, missPulse, gameOver
  );

  modport slave (
    input  startPulse, tick, moleButtonPulses, molePositions,
    output gameEnable, score, bestScore, timeLeft, hitPulse, missPulse, gameOver
  );
endinterface

// File: rtl/whackamole_game_ctrl_mole_hit_scorer.sv
// Classifies button presses against lit moles and counts the fresh hits.
// Latency: combinational, zero cycles.
// Backpressure: none.
// Ports: buttons_i/positions_i/hit_mask_i in; valid_o, wrong_o, count_o out.
module mole_hit_scorer
  import whackamole_pkg::*;
(
  input  logic [NUM_MOLES-1:0] buttons_i,
  input  logic [NUM_MOLES-1:0] positions_i,
  input  logic [NUM_MOLES-1:0] hit_mask_i,
  output logic [NUM_MOLES-1:0] valid_o,
  output logic [NUM_MOLES-1:0] wrong_o,
  output logic [HIT_CNT_W-1:0] count_o
);

  // A press scores only on a lit mole not already hit during this appearance.
  assign valid_o = buttons_i & positions_i & ~hit_mask_i;
  assign wrong_o = buttons_i & ~positions_i;

  always_comb begin
    count_o = '0;
    for (int i = 0; i < NUM_MOLES; i++) begin
      count_o = count_o + HIT_CNT_W'(valid_o[i]);
    end
  end

endmodule

// File: rtl/whackamole_game_ctrl.sv
// Round sequencer: start/time/end a round, score mole hits, keep best score.
// Latency: every output is registered, one clock after the causing input.
// Backpressure: none; input pulses are consumed in the cycle they arrive.
// Ports: clock, reset (sync, active-high), bus (slave modport): start/tick/
// buttons/positions in; gameEnable, score, bestScore, timeLeft, hit/miss
// pulses, gameOver out.
module whackamole_game_ctrl
  import whackamole_pkg::*;
#(
  parameter int GAME_SECONDS = DEFAULT_GAME_SECONDS,
  parameter int SCORE_W      = 8,
  parameter int TIME_W       = 6
) (
  input  logic                   clock,
  input  logic                   reset,
  whackamole_game_ctrl_if.slave  bus
);

  localparam logic [TIME_W-1:0]  TIME_LOAD = TIME_W'(GAME_SECONDS);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  game_state_e          state_q, state_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [SCORE_W-1:0]   best_q, best_d;
  logic [TIME_W-1:0]    time_q, time_d;
  logic                 hit_q, hit_d;
  logic                 miss_q, miss_d;
  logic [NUM_MOLES-1:0] mask_q, mask_d;
  logic [NUM_MOLES-1:0] pos_q;
  logic                 en_q, over_q;

  logic [NUM_MOLES-1:0] valid;
  logic [NUM_MOLES-1:0] wrong;
  logic [HIT_CNT_W-1:0] hit_cnt;
  logic [SCORE_W+2:0]   score_sum;

  mole_hit_scorer u_scorer (
    .buttons_i   (bus.moleButtonPulses),
    .positions_i (bus.molePositions),
    .hit_mask_i  (mask_q),
    .valid_o     (valid),
    .wrong_o     (wrong),
    .count_o     (hit_cnt)
  );

  // Wide enough that score + 5 can never wrap before the saturation check.
  assign score_sum = (SCORE_W+3)'(score_q) + (SCORE_W+3)'(hit_cnt);

  always_comb begin
    state_d = state_q;
    score_d = score_q;
    best_d  = best_q;
    time_d  = time_q;
    hit_d   = 1'b0;
    miss_d  = 1'b0;
    mask_d  = mask_q;

    // A mole going dark ends its appearance, so its hit bit is released.
    if (bus.molePositions != pos_q) begin
      mask_d = mask_q & bus.molePositions;
    end

    unique case (state_q)
      PLAY: begin
        if (score_sum > (SCORE_W+3)'(SCORE_MAX)) begin
          score_d = SCORE_MAX;
        end else begin
          score_d = score_sum[SCORE_W-1:0];
        end
        hit_d  = |valid;
        miss_d = |wrong;
        mask_d = mask_d | valid;
        if (bus.tick) begin
          if (time_q > TIME_W'(1)) begin
            time_d = time_q - TIME_W'(1);
          end else begin
            time_d  = '0;
            state_d = DONE;
            // Compare against the post-hit score so a last-cycle hit counts.
            if (score_d > best_q) begin
              best_d = score_d;
            end
          end
        end
      end
      default: begin
        // IDLE and DONE: start wins over any coincident tick.
        if (bus.startPulse) begin
          state_d = PLAY;
          score_d = '0;
          time_d  = TIME_LOAD;
          mask_d  = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      score_q <= '0;
      best_q  <= '0;
      time_q  <= TIME_LOAD;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
      mask_q  <= '0;
      pos_q   <= '0;
      en_q    <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      best_q  <= best_d;
      time_q  <= time_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      mask_q  <= mask_d;
      pos_q   <= bus.molePositions;
      en_q    <= (state_d == PLAY);
      over_q  <= (state_d == DONE);
    end
  end

  assign bus.gameEnable = en_q;
  assign bus.gameOver   = over_q;
  assign bus.score      = score_q;
  assign bus.bestScore  = best_q;
  assign bus.timeLeft   = time_q;
  assign bus.hitPulse   = hit_q;
  assign bus.missPulse  = miss_q;

endmodule

// File: tb/tb_whackamole_game_ctrl.sv
// Bench for the game controller: two instances (30 s / 8-bit, 3 s / 3-bit
// score) share one input stream and are compared every cycle to a model.
// Directed scenarios add literal expectations; a random phase follows.
module tb_whackamole_game_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start_r = 1'b0;
  logic       tick_r = 1'b0;
  logic [4:0] btn_r = '0;
  logic [4:0] pos_r = '0;
  bit         chk_en = 1'b0;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clock = ~clock;

  whackamole_game_ctrl_if #(.SCORE_W(8), .TIME_W(6)) bus_a ();
  whackamole_game_ctrl_if #(.SCORE_W(3), .TIME_W(6)) bus_b ();

  assign bus_a.startPulse       = start_r;
  assign bus_a.tick             = tick_r;
  assign bus_a.moleButtonPulses = btn_r;
  assign bus_a.molePositions    = pos_r;
  assign bus_b.startPulse       = start_r;
  assign bus_b.tick             = tick_r;
  assign bus_b.moleButtonPulses = btn_r;
  assign bus_b.molePositions    = pos_r;

  whackamole_game_ctrl #(.GAME_SECONDS(30), .SCORE_W(8), .TIME_W(6)) dut_a (
    .clock (clock), .reset (reset), .bus (bus_a));
  whackamole_game_ctrl #(.GAME_SECONDS(3), .SCORE_W(3), .TIME_W(6)) dut_b (
    .clock (clock), .reset (reset), .bus (bus_b));

  // ---------------- behavioural model ----------------
  // Round phase per instance: 0 waiting for first start, 1 playing, 2 round over.
  int       gs[2]   = '{30, 3};
  int       smax[2] = '{255, 7};
  int       m_phase[2], m_score[2], m_best[2], m_tleft[2];
  int       m_hit[2], m_miss[2];
  bit [4:0] m_hitset[2], m_prev[2];

  always @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_phase[i] = 0; m_score[i] = 0; m_best[i] = 0; m_tleft[i] = gs[i];
        m_hit[i] = 0; m_miss[i] = 0; m_hitset[i] = '0; m_prev[i] = '0;
      end else begin
        bit [4:0] fresh, bad;
        fresh = btn_r & pos_r & ~m_hitset[i];
        bad   = btn_r & ~pos_r;
        m_hit[i] = 0;
        m_miss[i] = 0;
        // Moles that are dark now have finished their appearance.
        m_hitset[i] = m_hitset[i] & pos_r;
        if (m_phase[i] == 1) begin
          m_score[i] = m_score[i] + $countones(fresh);
          if (m_score[i] > smax[i]) m_score[i] = smax[i];
          m_hit[i]  = (fresh != 0);
          m_miss[i] = (bad != 0);
          m_hitset[i] = m_hitset[i] | fresh;
          if (tick_r) begin
            m_tleft[i] = m_tleft[i] - 1;
            if (m_tleft[i] == 0) begin
              m_phase[i] = 2;
              if (m_score[i] > m_best[i]) m_best[i] = m_score[i];
            end
          end
        end else if (start_r) begin
          m_phase[i] = 1; m_score[i] = 0; m_tleft[i] = gs[i]; m_hitset[i] = '0;
        end
        m_prev[i] = pos_r;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (chk_en) begin
      chk("a.gameEnable", int'(bus_a.gameEnable), int'(m_phase[0] == 1));
      chk("a.gameOver",   int'(bus_a.gameOver),   int'(m_phase[0] == 2));
      chk("a.score",      int'(bus_a.score),      m_score[0]);
      chk("a.bestScore",  int'(bus_a.bestScore),  m_best[0]);
      chk("a.timeLeft",   int'(bus_a.timeLeft),   m_tleft[0]);
      chk("a.hitPulse",   int'(bus_a.hitPulse),   m_hit[0]);
      chk("a.missPulse",  int'(bus_a.missPulse),  m_miss[0]);
      chk("b.gameEnable", int'(bus_b.gameEnable), int'(m_phase[1] == 1));
      chk("b.gameOver",   int'(bus_b.gameOver),   int'(m_phase[1] == 2));
      chk("b.score",      int'(bus_b.score),      m_score[1]);
      chk("b.bestScore",  int'(bus_b.bestScore),  m_best[1]);
      chk("b.timeLeft",   int'(bus_b.timeLeft),   m_tleft[1]);
      chk("b.hitPulse",   int'(bus_b.hitPulse),   m_hit[1]);
      chk("b.missPulse",  int'(bus_b.missPulse),  m_miss[1]);
    end
  end

  // Apply one cycle of inputs; returns 1 time unit after the consuming edge,
  // so outputs then reflect exactly these inputs.
  task automatic step(input bit s, input bit t, input bit [4:0] b, input bit [4:0] p);
    start_r = s; tick_r = t; btn_r = b; pos_r = p;
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk_en = 1'b1;
    step(0, 0, 5'b0, 5'b0);
    reset = 1'b0;

    // 1: idle with random ticks, buttons and moles; nothing may move.
    for (int i = 0; i < 100; i++)
      step(0, 1'($urandom_range(0, 1)), 5'($urandom), 5'($urandom));
    chk("idle.score",      int'(bus_a.score), 0);
    chk("idle.timeLeft",   int'(bus_a.timeLeft), 30);
    chk("idle.gameEnable", int'(bus_a.gameEnable), 0);
    chk("idle.gameOver",   int'(bus_a.gameOver), 0);

    // 2: first hit scores, repeat press on the same appearance is silent.
    step(1, 0, 5'b0, 5'b00100);
    chk("start.gameEnable", int'(bus_a.gameEnable), 1);
    step(0, 0, 5'b0, 5'b00100);
    step(0, 0, 5'b00100, 5'b00100);
    chk("hit.score",    int'(bus_a.score), 1);
    chk("hit.hitPulse", int'(bus_a.hitPulse), 1);
    step(0, 0, 5'b00100, 5'b00100);
    chk("rehit.score", int'(bus_a.score), 1);
    chk("rehit.hit",   int'(bus_a.hitPulse), 0);
    chk("rehit.miss",  int'(bus_a.missPulse), 0);

    // 3: miss on a dark mole, then a double hit.
    step(0, 0, 5'b0, 5'b00001);
    step(0, 0, 5'b01000, 5'b00001);
    chk("miss.missPulse", int'(bus_a.missPulse), 1);
    chk("miss.score",     int'(bus_a.score), 1);
    step(0, 0, 5'b0, 5'b10001);
    step(0, 0, 5'b10001, 5'b10001);
    chk("double.score", int'(bus_a.score), 3);

    // 4: mole 0 dark then re-lit twice, one point per appearance.
    step(0, 0, 5'b0, 5'b00000);
    step(0, 0, 5'b0, 5'b00001);
    step(0, 0, 5'b00001, 5'b00001);
    step(0, 0, 5'b0, 5'b00000);
    step(0, 0, 5'b0, 5'b00001);
    step(0, 0, 5'b00001, 5'b00001);
    chk("relight.score", int'(bus_a.score), 5);

    // 5: short round on instance b, hit on the final tick counts.
    step(0, 0, 5'b0, 5'b00010);
    step(0, 1, 5'b0, 5'b00010);
    step(0, 1, 5'b0, 5'b00010);
    step(0, 1, 5'b00010, 5'b00010);
    chk("end.b.timeLeft",  int'(bus_b.timeLeft), 0);
    chk("end.b.gameOver",  int'(bus_b.gameOver), 1);
    chk("end.b.score",     int'(bus_b.score), 6);
    chk("end.b.bestScore", int'(bus_b.bestScore), 6);
    chk("end.a.timeLeft",  int'(bus_a.timeLeft), 27);
    step(1, 0, 5'b0, 5'b00010);
    step(0, 0, 5'b00010, 5'b00010);
    step(0, 1, 5'b0, 5'b00010);
    step(0, 1, 5'b0, 5'b00010);
    step(0, 1, 5'b0, 5'b00010);
    chk("low.b.score",     int'(bus_b.score), 1);
    chk("low.b.bestScore", int'(bus_b.bestScore), 6);
    chk("low.b.gameOver",  int'(bus_b.gameOver), 1);
    chk("low.a.score",     int'(bus_a.score), 6);

    // 6: saturation on the 3-bit score, then reset mid-round.
    step(1, 0, 5'b0, 5'b11111);
    step(0, 0, 5'b11111, 5'b11111);
    step(0, 0, 5'b0, 5'b00000);
    step(0, 0, 5'b0, 5'b11111);
    step(0, 0, 5'b11111, 5'b11111);
    chk("sat.b.score", int'(bus_b.score), 7);
    chk("sat.a.score", int'(bus_a.score), 15);
    reset = 1'b1;
    step(0, 0, 5'b0, 5'b11111);
    reset = 1'b0;
    chk("rst.a.score",      int'(bus_a.score), 0);
    chk("rst.a.bestScore",  int'(bus_a.bestScore), 0);
    chk("rst.a.timeLeft",   int'(bus_a.timeLeft), 30);
    chk("rst.a.gameEnable", int'(bus_a.gameEnable), 0);
    chk("rst.b.bestScore",  int'(bus_b.bestScore), 0);
    chk("rst.b.timeLeft",   int'(bus_b.timeLeft), 3);
    chk("rst.b.gameOver",   int'(bus_b.gameOver), 0);

    // Random phase: sparse starts, ticks, presses, and occasional resets.
    for (int i = 0; i < 4000; i++) begin
      bit [4:0] p;
      p = ($urandom_range(0, 3) == 0) ? 5'($urandom) : pos_r;
      reset = ($urandom_range(0, 699) == 0);
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 5) == 0),
           5'($urandom & $urandom), p);
    end
    reset = 1'b0;
    step(0, 0, 5'b0, pos_r);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/whackamole_game_ctrl.md
Name: whackamole_game_ctrl

Overview:
Game sequencer for the whack-a-mole design. It starts, times and ends a round, and gates the mole generator through `gameEnable`. It scores debounced mole-button pulses against the live mole positions, with one hit per mole appearance. It tracks the remaining seconds and the best score since reset, for the segment-display path.

Parameters:
GAME_SECONDS, 30, round length in 1 Hz ticks (1..63)
SCORE_W, 8, width of the score and best-score registers
TIME_W, 6, width of the time-remaining counter

Ports:
clock  input  1  100 MHz system clock
reset  input  1  synchronous, active-high reset
startPulse  input  1  debounced start button, one-cycle pulse
tick  input  1  1 Hz enable, one-cycle pulse in the clock domain
moleButtonPulses  input  5  debounced mole buttons, one-cycle pulses per press
molePositions  input  5  currently lit moles, from mole_generator
gameEnable  output  1  high only in PLAY; drives the mole_generator enable
score  output  SCORE_W  current round score
bestScore  output  SCORE_W  highest completed-round score since reset
timeLeft  output  TIME_W  seconds remaining in the round
hitPulse  output  1  one-cycle pulse when at least one valid hit is scored
missPulse  output  1  one-cycle pulse when a pressed button has no lit mole
gameOver  output  1  high in DONE

Behaviour:
- Single clock domain. Reset is synchronous and active-high: sampled on posedge `clock` only.
- Reset values:
  - state = IDLE
  - gameEnable = 0, gameOver = 0
  - score = 0, bestScore = 0
  - timeLeft = GAME_SECONDS
  - hitPulse = 0, missPulse = 0
  - hitMask = 0
- All outputs are registered. An event on the inputs appears on the outputs exactly one clock later.
- FSM states: IDLE, PLAY, DONE.
  - IDLE: on `startPulse`, go to PLAY; score <= 0, timeLeft <= GAME_SECONDS, hitMask <= 0. `tick` and mole buttons are ignored.
  - PLAY: gameEnable = 1.
    - On `tick` with timeLeft > 1: decrement timeLeft.
    - On `tick` with timeLeft == 1: timeLeft <= 0 and go to DONE.
    - `startPulse` is ignored.
  - DONE: gameOver = 1, gameEnable = 0, score frozen.
    - On `startPulse`: same action as from IDLE, then go to PLAY.
- Best score: bestScore <= score on the PLAY->DONE transition, if score > bestScore. The comparison includes any hits scored in that final cycle.
- Scoring, in PLAY only:
  - valid = moleButtonPulses & molePositions & ~hitMask
  - wrong = moleButtonPulses & ~molePositions
  - score <= score + popcount(valid), saturating at 2^SCORE_W-1.
  - hitPulse <= |valid.
  - missPulse <= |wrong.
  - Misses do not change the score.
  - A press on a lit mole already in hitMask raises neither hitPulse nor missPulse.
- hitMask:
  - Set bits: hitMask <= hitMask | valid.
  - Clear bits: when molePositions changes from the previous cycle, clear every hitMask bit whose molePositions bit is now 0. A mole re-lit after going dark can therefore score again.
  - A registered copy of molePositions is kept for this change detection.
- Simultaneous events:
  - Hit and final tick in the same cycle: the hit counts. The score and the best-score compare both include it.
  - startPulse and tick in the same cycle in IDLE or DONE: start wins; timeLeft loads GAME_SECONDS with no decrement.
  - Valid hits on multiple moles in one cycle: all count (popcount up to 5).
- Reset mid-round: returns to IDLE and clears everything, including bestScore.

Decomposition:
- Shared package whackamole_pkg holds:
  - the state encoding (IDLE=2'd0, PLAY=2'd1, DONE=2'd2);
  - NUM_MOLES = 5;
  - the default GAME_SECONDS.
- One sub-module, mole_hit_scorer. Combinational. Inputs: buttons, positions, hitMask. Outputs: valid, wrong, popcount. It is instantiated once.
- The FSM, timer, score, best-score and hitMask registers stay in the top controller.

Test Plan:
1. Reset, then idle 100 cycles with random tick and button pulses -> score = 0, timeLeft = 30, gameEnable = 0, gameOver = 0.
2. startPulse; molePositions = 5'b00100; press bit 2 -> one cycle later score = 1, hitPulse = 1. Press bit 2 again while the mole stays lit -> score stays 1, no hitPulse or missPulse.
3. In PLAY with molePositions = 5'b00001, press bit 3 -> missPulse = 1, score unchanged. Press bits 0 and 4 with molePositions = 5'b10001 -> score += 2.
4. Drop mole 0, then re-light it (5'b00001 -> 5'b00000 -> 5'b00001); press bit 0 after each lighting -> two points scored.
5. GAME_SECONDS = 3: start, 3 ticks, a hit in the same cycle as the 3rd tick -> timeLeft = 0, gameOver = 1, final score includes that hit, bestScore = score. Restart and score lower -> bestScore unchanged.
6. SCORE_W = 3: score 7 hits -> score saturates at 7. Reset mid-PLAY -> all outputs return to their reset values on the next cycle.
